// File: rtl/glip_deframer_pkg.sv
// Shared types and helpers for the GLIP packet deframer.
package glip_deframer_pkg;

    typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

    // Caller zero-extends the counter and truncates the result back to its width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v == max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/glip_out_reg.sv
// One-entry stream output register with load/unload handshake and a discard input.
module glip_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk_logic,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             valid
);

    always_ff @(posedge clk_logic) begin
        if (rst) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (clear) begin
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            // A load on the same edge as an unload refills with no bubble.
            data  <= load_data;
            last  <= load_last;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/glip_packet_deframer.sv
// Splits the GLIP backend word stream into length-prefixed packets, drops oversized ones.
module glip_packet_deframer
    import glip_deframer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_logic,
    input  logic             rst,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic             out_free;
    logic             in_fire;
    logic             load;

    assign out_free = !out_valid || out_ready;
    assign in_ready = !rst && !abort && ((state == S_DROP) || out_free);
    assign in_fire  = in_valid && in_ready;
    assign load     = in_fire && (state == S_PAY);

    always_ff @(posedge clk_logic) begin
        if (rst) begin
            state   <= S_HDR;
            rem     <= '0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (abort) begin
            state <= S_HDR;
            rem   <= '0;
            if (state != S_HDR)
                err_cnt <= CNT_W'(sat_inc(64'(err_cnt), CNT_MAX));
        end else if (in_fire) begin
            case (state)
                S_HDR: begin
                    // A zero-length header is a keepalive and leaves everything untouched.
                    if (in_data > WIDTH'(MAX_LEN)) begin
                        rem     <= in_data;
                        state   <= S_DROP;
                        err_cnt <= CNT_W'(sat_inc(64'(err_cnt), CNT_MAX));
                    end else if (in_data != '0) begin
                        rem   <= in_data;
                        state <= S_PAY;
                    end
                end
                S_PAY: begin
                    rem <= rem - 1'b1;
                    if (rem == WIDTH'(1)) begin
                        state   <= S_HDR;
                        pkt_cnt <= CNT_W'(sat_inc(64'(pkt_cnt), CNT_MAX));
                    end
                end
                S_DROP: begin
                    rem <= rem - 1'b1;
                    if (rem == WIDTH'(1))
                        state <= S_HDR;
                end
                default: state <= S_HDR;
            endcase
        end
    end

    glip_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk_logic (clk_logic),
        .rst       (rst),
        .clear     (abort),
        .load      (load),
        .load_data (in_data),
        .load_last (rem == WIDTH'(1)),
        .ready     (out_ready),
        .data      (out_data),
        .last      (out_last),
        .valid     (out_valid)
    );

endmodule

// File: tb/tb_glip_packet_deframer.sv
// Randomized bench for glip_packet_deframer against a packet-level expected-output queue.
module tb_glip_packet_deframer;

    localparam int W    = 16;
    localparam int ML   = 64;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_logic = 1'b0;
    logic          rst = 1'b1;
    logic          abort = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;

    glip_packet_deframer #(.WIDTH(W), .MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk_logic (clk_logic),
        .rst       (rst),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk_logic = ~clk_logic;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] in_q[$];
    logic [W:0]   exp_q[$];
    int           exp_pkt = 0;
    int           exp_err = 0;
    int           valid_pct = 100;
    int           ready_mode = 0;
    int           ready_ph = 0;
    bit           full_thru = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W:0]   prev_word = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Packet-level model: the whole fate of a packet is decided when it is queued.
    function automatic void add_pkt(input int n, input logic [W-1:0] base);
        in_q.push_back(W'(n));
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] w;
            w = base + W'(i);
            in_q.push_back(w);
            if (n <= ML) exp_q.push_back({(i == n - 1), w});
        end
        if (n > ML) exp_err++;
        else if (n > 0) exp_pkt++;
    endfunction

    task automatic drive_next();
        in_valid = (in_q.size() > 0) && ($urandom_range(99) < valid_pct);
        in_data  = in_valid ? in_q[0] : '0;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
            2: out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b0;
        endcase
        ready_ph++;
    endtask

    task automatic cycle();
        @(negedge clk_logic);
        if (prev_stall) check("hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
        if (out_valid && !out_ready) check("stall_rdy", in_ready, 0);
        if (full_thru && in_q.size() > 0) check("full_thru", in_ready, 1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", {out_last, out_data}, 64'hdead_0000);
            else check("out_word", {out_last, out_data}, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
        if (in_valid && in_ready) void'(in_q.pop_front());
        @(posedge clk_logic);
        #1;
        drive_next();
    endtask

    task automatic run(input int budget);
        int c = 0;
        drive_next();
        while ((in_q.size() > 0 || exp_q.size() > 0 || out_valid) && c < budget) begin
            cycle();
            c++;
        end
        if (c >= budget) check("timeout", c, 0);
        full_thru = 1'b0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_pkt"}, pkt_cnt, clamp(exp_pkt));
        check({tag, "_err"}, err_cnt, clamp(exp_err));
    endtask

    initial begin
        repeat (2) @(posedge clk_logic);
        #1;
        @(negedge clk_logic);
        check("rst_in_ready", in_ready, 0);
        check("rst_out", {out_valid, out_last, out_data}, 0);
        check("rst_cnt", {pkt_cnt, err_cnt}, 0);
        @(posedge clk_logic);
        #1;
        rst = 1'b0;

        // Full throughput, single packet.
        ready_mode = 0; valid_pct = 100; full_thru = 1'b1;
        add_pkt(3, 16'h00a1);
        run(100);
        check_cnts("t1");

        // Stalling consumer.
        ready_mode = 1; ready_ph = 0;
        add_pkt(3, 16'h00a1);
        run(100);
        check_cnts("t2");

        // Keepalive then a real packet.
        ready_mode = 0;
        add_pkt(0, 16'h0);
        add_pkt(2, 16'h00b1);
        run(100);
        check_cnts("t3");

        // Oversized packet dropped, next one delivered.
        add_pkt(ML + 1, 16'h1000);
        add_pkt(1, 16'h00c1);
        run(500);
        check_cnts("t4");

        // Abort mid-packet with a word held in the output register.
        ready_mode = 3;
        add_pkt(4, 16'h00e0);
        exp_q.delete();
        exp_pkt--;
        drive_next();
        repeat (3) cycle();
        in_q.delete();
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk_logic);
        check("abort_rdy", in_ready, 0);
        @(posedge clk_logic);
        #1;
        abort = 1'b0;
        prev_stall = 1'b0;
        exp_err++;
        @(negedge clk_logic);
        check("abort_ov", out_valid, 0);
        @(posedge clk_logic);
        #1;
        ready_mode = 0;
        add_pkt(1, 16'h00d1);
        run(100);
        check_cnts("t5");

        // Random mix of lengths, gaps and backpressure.
        ready_mode = 2; valid_pct = 70;
        for (int p = 0; p < 40; p++) begin
            int r, n;
            r = $urandom_range(9);
            if (r == 0) n = 0;
            else if (r == 1) n = ML;
            else if (r == 2) n = ML + 1 + $urandom_range(5);
            else n = $urandom_range(8, 1);
            add_pkt(n, W'($urandom));
        end
        run(20000);
        check_cnts("rand");

        // Counter saturation.
        ready_mode = 0; valid_pct = 100;
        for (int p = 0; p < CMAX + 40; p++) add_pkt(1, W'(p));
        run(5000);
        check_cnts("sat");

        // Reset in the middle of a packet.
        ready_mode = 3;
        add_pkt(5, 16'h0f00);
        exp_q.delete();
        drive_next();
        repeat (3) cycle();
        in_q.delete();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk_logic);
        #1;
        prev_stall = 1'b0;
        @(negedge clk_logic);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out", {out_valid, out_last, out_data}, 0);
        check("mid_rst_cnt", {pkt_cnt, err_cnt}, 0);
        @(posedge clk_logic);
        #1;
        rst = 1'b0;
        exp_pkt = 0; exp_err = 0;
        ready_mode = 0;
        add_pkt(2, 16'h0aa0);
        run(100);
        check_cnts("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
